// File: rtl/tx_serial_arbiter.sv
// Purpose : round-robin share of one tx_serial serializer among N requesters.
// Latency : valid in IDLE -> ser_start_o one cycle later; done -> next start >= GAP+2.
// Backpres: one word accepted per grant (req_ready_o one-hot, only in IDLE with valid).
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   req_valid_i/req_data_i    per-requester valid and word (word k at [k*DW +: DW])
//   req_ready_o               one-hot accept strobe, combinational from valid
//   dvsr_i                    divisor captured with the accepted word
//   ser_start_o/ser_data_o/ser_dvsr_o/ser_done_i   serializer handshake
//   grant_o                   one-hot owner of the frame in flight, 0 otherwise
//   busy_o                    high outside IDLE
//   err_o/err_clr_i           sticky done-timeout flag and its clear
// Optional: TX_ARB_STATS_EN adds frame_cnt_o, a 16-bit completed-frame counter per requester.
module tx_serial_arbiter #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int VW      = 16,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic [0:0]      clk_i,
  input  logic [0:0]      rst_i,
  input  logic [N-1:0]    req_valid_i,
  input  logic [N*DW-1:0] req_data_i,
  output logic [N-1:0]    req_ready_o,
  input  logic [VW-1:0]   dvsr_i,
  output logic            ser_start_o,
  output logic [DW-1:0]   ser_data_o,
  output logic [VW-1:0]   ser_dvsr_o,
  input  logic [0:0]      ser_done_i,
  output logic [N-1:0]    grant_o,
  output logic            busy_o,
  output logic            err_o,
  input  logic [0:0]      err_clr_i
`ifdef TX_ARB_STATS_EN
  ,
  output logic [N*16-1:0] frame_cnt_o
`endif
);

  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr;          // index of the last granted requester
  logic [PW-1:0]   win_idx;
  logic            win_vld;
  logic [CW-1:0]   cnt;         // BUSY timeout count or GAP count, cleared on every state change
  logic            take;
  logic            done_acc;
  logic            tmo_hit;
  logic            frame_end;

  // Scan from the farthest offset back to the nearest so the first valid index
  // at or after rr+1 is the last assignment and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr;
    for (int i = N; i >= 1; i--) begin
      if (req_valid_i[(int'(rr) + i) % N]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(rr) + i) % N);
      end
    end
  end

  // A done coinciding with the start pulse belongs to no frame of ours.
  assign done_acc  = (state == S_BUSY) && !ser_start_o && ser_done_i[0];
  // Done has priority, so a timeout only fires when no done is accepted this cycle.
  assign tmo_hit   = (TIMEOUT > 0) && (state == S_BUSY) && !done_acc && (int'(cnt) == TIMEOUT - 1);
  assign frame_end = done_acc || tmo_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    take        = 1'b0;
    busy_o      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // Gated by reset so the combinational strobe is also 0 while reset is held.
        if (win_vld && !rst_i[0]) begin
          take                 = 1'b1;
          req_ready_o[win_idx] = 1'b1;
          state_nxt            = S_BUSY;
        end
      end
      S_BUSY: begin
        if (frame_end) state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (int'(cnt) == GAP - 1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr          <= PW'(N - 1);
      cnt         <= '0;
      ser_start_o <= 1'b0;
      ser_data_o  <= '0;
      ser_dvsr_o  <= '0;
      grant_o     <= '0;
      err_o       <= 1'b0;
    end else begin
      ser_start_o <= take;
      cnt         <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (take) begin
        ser_data_o <= req_data_i[int'(win_idx)*DW +: DW];
        ser_dvsr_o <= dvsr_i;
        grant_o    <= req_ready_o;
        rr         <= win_idx;
      end else if (frame_end) begin
        grant_o <= '0;
      end
      if (err_clr_i[0])  err_o <= 1'b0;
      else if (tmo_hit)  err_o <= 1'b1;
    end
  end

`ifdef TX_ARB_STATS_EN
  // rr still names the frame owner while in BUSY; timeouts are not counted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_o <= '0;
    end else if (done_acc) begin
      frame_cnt_o[int'(rr)*16 +: 16] <= frame_cnt_o[int'(rr)*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule
